// File: rtl/lu_pkg.sv
// lu_pkg: shared types and helpers for the band LU wavefront sequencer.
//   lu_w(p, q)         number of band diagonals / lanes, p+q-1
//   lu_steps(n)        issue steps per matrix, 3n-2
//   lu_absdiag(k, p)   |d| for lane k, where d = k-(p-1)
//   lu_state_e         sequencer states
//   lu_elem_t          one matrix element at the default width
package lu_pkg;

  localparam int unsigned LU_DW = 8;

  typedef logic [LU_DW-1:0] lu_elem_t;

  typedef enum logic [1:0] {
    LOAD,
    ISSUE,
    DRAIN,
    DONE
  } lu_state_e;

  function automatic int unsigned lu_w(input int unsigned p, input int unsigned q);
    return p + q - 1;
  endfunction

  function automatic int unsigned lu_steps(input int unsigned n);
    return 3 * n - 2;
  endfunction

  function automatic int unsigned lu_absdiag(input int unsigned k, input int unsigned p);
    return (k >= p - 1) ? k - (p - 1) : (p - 1) - k;
  endfunction

endpackage

// File: rtl/lu_band_row_buffer.sv
// lu_band_row_buffer: N rows x W lanes x DW bits register file, not reset.
//   clk     clock
//   we      write enable
//   waddr   row written when we is high
//   wdata   full row (W lanes of DW bits)
//   raddr   per-lane row index; indices >= N read as zero
//   rdata   lane k carries lane k of row raddr[k]
module lu_band_row_buffer #(
  parameter int unsigned DW = 8,
  parameter int unsigned N  = 8,
  parameter int unsigned W  = 7,
  parameter int unsigned AW = 3,
  parameter int unsigned RW = 4
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [W*DW-1:0]        wdata,
  input  logic [W-1:0][RW-1:0]   raddr,
  output logic [W*DW-1:0]        rdata
);

  logic [W*DW-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < W; k++) begin : g_rd
    always_comb begin
      rdata[k*DW +: DW] = '0;
      if (32'(raddr[k]) < N) begin
        rdata[k*DW +: DW] = mem_q[raddr[k][AW-1:0]][k*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/lu_band_sequencer.sv
// lu_band_sequencer: buffers an N x N band matrix (one row per beat) and
// issues it as W = P+Q-1 skewed diagonal lanes on a 3-cycle wavefront,
// then waits LAT cycles and pulses done.
//   clk, rst     clock, synchronous active-high reset
//   in_valid     row beat valid
//   in_ready     high in LOAD
//   in_row       lane k holds a(i, i+k-(P-1))
//   line_valid   issue cycle active (registered)
//   line_data    lane k = diagonal k-(P-1) element or zero (registered)
//   step         current issue step
//   busy         not in LOAD
//   done         one-cycle completion pulse
module lu_band_sequencer
  import lu_pkg::*;
#(
  parameter int unsigned DW  = LU_DW,
  parameter int unsigned N   = 8,
  parameter int unsigned P   = 4,
  parameter int unsigned Q   = 4,
  parameter int unsigned LAT = 12,
  localparam int unsigned W  = lu_w(P, Q),
  localparam int unsigned SW = $clog2(lu_steps(N))
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*DW-1:0] in_row,
  output logic            line_valid,
  output logic [W*DW-1:0] line_data,
  output logic [SW-1:0]   step,
  output logic            busy,
  output logic            done
);

  localparam int unsigned T    = lu_steps(N);
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned RW   = $clog2(N + W + 1);
  localparam int unsigned MAXD = ((P > Q) ? P : Q) - 1;
  localparam int unsigned CW   = $clog2(((MAXD > 2) ? MAXD : 2) + 1);
  localparam int unsigned DCW  = $clog2(LAT + 1);

  lu_state_e          state_q, state_d;
  logic [AW-1:0]      r_q, r_d;
  logic [SW-1:0]      step_q, step_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic               line_valid_q, line_valid_d;
  logic [W*DW-1:0]    line_data_q, line_data_d;

  logic               last_row;
  logic               last_step;
  logic               advance;
  logic               wr_en;
  logic [W-1:0][RW-1:0] raddr;
  logic [W*DW-1:0]    rdata;
  logic [W*DW-1:0]    lane_data;

  lu_band_row_buffer #(
    .DW (DW),
    .N  (N),
    .W  (W),
    .AW (AW),
    .RW (RW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (r_q),
    .wdata (in_row),
    .raddr (raddr),
    .rdata (rdata)
  );

  // advance is high in every cycle that computes the line for the next
  // step: the final accept (step 0) and each ISSUE cycle but the last.
  always_comb begin
    last_row  = (r_q == AW'(N - 1));
    last_step = (step_q == SW'(T - 1));
    advance   = ((state_q == LOAD) && in_valid && last_row) ||
                ((state_q == ISSUE) && !last_step);
    wr_en     = (state_q == LOAD) && in_valid && !rst;
  end

  // Per lane: countdown phase (|d| first, then period 3) and the buffer row
  // of the lane's next element; replaces a divide of (t-|d|) by 3.
  for (genvar k = 0; k < W; k++) begin : g_lane
    localparam int unsigned AD  = lu_absdiag(k, P);
    localparam bit          NEG = (k < P - 1);

    logic [CW-1:0] ph_q, ph_d;
    logic [RW-1:0] ri_q, ri_d;
    logic          emit;

    always_comb begin
      ph_d = ph_q;
      ri_d = ri_q;
      if (advance) begin
        if (ph_q == '0) begin
          ph_d = CW'(2);
          ri_d = ri_q + 1'b1;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end else if (state_q != ISSUE) begin
        ph_d = CW'(AD);
        ri_d = NEG ? RW'(AD) : '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ph_q <= CW'(AD);
        ri_q <= NEG ? RW'(AD) : '0;
      end else begin
        ph_q <= ph_d;
        ri_q <= ri_d;
      end
    end

    // Upper diagonals also need column i+d inside the matrix.
    always_comb begin
      emit = (ph_q == '0) && (32'(ri_q) < N) && (NEG || (32'(ri_q) + AD < N));
    end

    assign raddr[k]               = ri_q;
    assign lane_data[k*DW +: DW]  = emit ? rdata[k*DW +: DW] : '0;
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    step_d       = '0;
    drain_d      = drain_q;
    line_valid_d = 1'b0;
    line_data_d  = '0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (last_row) begin
            state_d      = ISSUE;
            r_d          = '0;
            line_valid_d = 1'b1;
            line_data_d  = lane_data;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        if (last_step) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          step_d       = step_q + 1'b1;
          line_valid_d = 1'b1;
          line_data_d  = lane_data;
        end
      end
      DRAIN: begin
        if (drain_q == DCW'(LAT - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = LOAD;
        r_d     = '0;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      r_q          <= '0;
      step_q       <= '0;
      drain_q      <= '0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      step_q       <= step_d;
      drain_q      <= drain_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q != LOAD);
  assign done       = (state_q == DONE);
  assign line_valid = line_valid_q;
  assign line_data  = line_data_q;
  assign step       = step_q;

endmodule
